// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  // Receiver FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Parity_Type encodings
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Total bits on the line for one frame: start + data + optional parity + stop
  function automatic int unsigned frame_bits(input int unsigned data_width,
                                             input logic        parity_en);
    return data_width + 32'(parity_en) + 32'd2;
  endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// Line synchronizer, per-bit edge counter and 3-sample mid-bit majority vote.
module uart_rx_bit_sampler #(
  parameter int unsigned PRESCALE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  input  logic fsm_idle,
  output logic fall_c,
  output logic sample_valid_c,
  output logic bit_end_c,
  output logic bit_vote_c
);

  localparam int unsigned    CNT_W    = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] MID_LO   = CNT_W'(PRESCALE / 2 - 1);
  localparam logic [CNT_W-1:0] MID      = CNT_W'(PRESCALE / 2);
  localparam logic [CNT_W-1:0] MID_HI   = CNT_W'(PRESCALE / 2 + 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             hist_q, hist_d;
  logic             s_lo_q, s_lo_d;
  logic             s_mid_q, s_mid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign fall_c         = hist_q & ~sync2_q;
  assign sample_valid_c = ~fsm_idle & (cnt_q == MID_HI);
  assign bit_end_c      = ~fsm_idle & (cnt_q == CNT_LAST);
  assign bit_vote_c     = (s_lo_q & s_mid_q) | (s_lo_q & sync2_q) | (s_mid_q & sync2_q);

  // Next-state: sync chain, bit-period counter (0 at T0) and early vote taps
  always_comb begin
    sync1_d = rx_in;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    s_lo_d  = s_lo_q;
    s_mid_d = s_mid_q;
    cnt_d   = cnt_q;
    if (fsm_idle) begin
      cnt_d = fall_c ? CNT_W'(1) : '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (cnt_q == MID_LO) s_lo_d  = sync2_q;
    if (cnt_q == MID)    s_mid_d = sync2_q;
  end

  // Registers; line flops reset high so reset release never looks like a start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
      s_lo_q  <= 1'b1;
      s_mid_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      s_lo_q  <= s_lo_d;
      s_mid_q <= s_mid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: frame FSM, deserializer, parity/stop checks, registered result pulses.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  Parity_Enable,
  input  logic                  Parity_Type,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error
);

  if ((PRESCALE < 4) || ((PRESCALE % 2) != 0)) begin : g_bad_prescale
    $error("uart_rx_core: PRESCALE must be even and >= 4");
  end

  localparam int unsigned       BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  logic fall_c, sample_valid_c, bit_end_c, bit_vote_c, fsm_idle_c, exp_parity_c;

  rx_state_e             state_q, state_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_type_q, par_type_d;
  logic                  par_bit_q, par_bit_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  parity_err_q, parity_err_d;
  logic                  stop_err_q, stop_err_d;

  uart_rx_bit_sampler #(
    .PRESCALE (PRESCALE)
  ) u_sampler (
    .clk            (CLK),
    .rst            (RST),
    .rx_in          (RX_IN),
    .fsm_idle       (fsm_idle_c),
    .fall_c         (fall_c),
    .sample_valid_c (sample_valid_c),
    .bit_end_c      (bit_end_c),
    .bit_vote_c     (bit_vote_c)
  );

  assign fsm_idle_c   = (state_q == ST_IDLE);
  assign exp_parity_c = (^shift_q) ^ (par_type_q == PARITY_ODD);

  assign P_DATA       = p_data_q;
  assign Data_Valid   = data_valid_q;
  assign Parity_Error = parity_err_q;
  assign Stop_Error   = stop_err_q;

  // Frame sequencing and stop-bit decision; result pulses default low
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_en_d     = par_en_q;
    par_type_d   = par_type_q;
    par_bit_d    = par_bit_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    parity_err_d = 1'b0;
    stop_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall_c) begin
          state_d    = ST_START;
          par_en_d   = Parity_Enable;
          par_type_d = Parity_Type;
        end
      end
      ST_START: begin
        if (sample_valid_c && bit_vote_c) begin
          state_d = ST_IDLE;
        end else if (bit_end_c) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (sample_valid_c) shift_d[bit_cnt_q] = bit_vote_c;
        if (bit_end_c) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (sample_valid_c) par_bit_d = bit_vote_c;
        if (bit_end_c)      state_d   = ST_STOP;
      end
      ST_STOP: begin
        if (sample_valid_c) begin
          parity_err_d = par_en_q && (par_bit_q != exp_parity_c);
          stop_err_d   = ~bit_vote_c;
          if (!parity_err_d && !stop_err_d) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_type_q   <= 1'b0;
      par_bit_q    <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      stop_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_en_q     <= par_en_d;
      par_type_q   <= par_type_d;
      par_bit_q    <= par_bit_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      stop_err_q   <= stop_err_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed scenarios plus random frames against a frame-level model.
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned P  = 8;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  flags;   // {Data_Valid, Parity_Error, Stop_Error}
    logic [7:0]  data;
  } evt_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic          pen = 1'b0;
  logic          ptype = 1'b0;
  logic [DW-1:0] p_data;
  logic          dv, perr, serr;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned pulse_cnt = 0;
  int unsigned dv_cnt    = 0;
  logic [7:0]  model_pdata = 8'h00;
  evt_t        exp_q[$];
  evt_t        got_e;

  uart_rx_core #(.DATA_WIDTH(DW), .PRESCALE(P)) dut (
    .CLK           (clk),
    .RST           (rst),
    .RX_IN         (rx),
    .Parity_Enable (pen),
    .Parity_Type   (ptype),
    .P_DATA        (p_data),
    .Data_Valid    (dv),
    .Parity_Error  (perr),
    .Stop_Error    (serr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Result monitor: every pulse must match the next predicted frame outcome
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check("evt_missing", cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (dv || perr || serr) begin
      pulse_cnt++;
      if (dv) dv_cnt++;
      if (exp_q.size() == 0) begin
        check("evt_unexpected", 32'({dv, perr, serr}), 32'd0);
      end else begin
        got_e = exp_q.pop_front();
        check("evt_cycle", cyc, got_e.cyc);
        check("evt_flags", 32'({dv, perr, serr}), 32'(got_e.flags));
        check("evt_p_data", 32'(p_data), 32'(got_e.data));
      end
    end
  end

  // Drive one frame and predict its outcome; entered and left just after a posedge
  task automatic send_frame(input logic [7:0] data, input logic p_en, input logic p_type,
                            input logic flip, input logic stop_bit, input int unsigned gap);
    logic        bits[$];
    evt_t        e;
    int unsigned n;
    logic        pe_exp, se_exp;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (p_en) bits.push_back((^data) ^ p_type ^ flip);
    bits.push_back(stop_bit);
    n      = frame_bits(DW, p_en);
    pe_exp = p_en & flip;
    se_exp = ~stop_bit;
    if (!pe_exp && !se_exp) model_pdata = data;
    pen   = p_en;
    ptype = p_type;
    e.cyc   = cyc + 2 + (n - 1) * P + P / 2 + 2;
    e.flags = {~pe_exp & ~se_exp, pe_exp, se_exp};
    e.data  = model_pdata;
    exp_q.push_back(e);
    for (int i = 0; i < bits.size(); i++) begin
      rx = bits[i];
      if (i == 1) begin
        pen   = 1'($urandom);
        ptype = 1'($urandom);
      end
      repeat (P) @(posedge clk);
      #1;
    end
    if (gap > 0) begin
      rx = 1'b1;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_cycles(input int unsigned n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int unsigned mark;
  int unsigned t_g;
  logic [7:0]  rd;
  logic        r_pen, r_flip, r_stop;
  int unsigned r_gap;

  initial begin
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;

    // Quiet line after reset
    idle_cycles(500);
    check("quiet_pulses", pulse_cnt, 0);
    check("quiet_p_data", 32'(p_data), 32'h0);

    // 8N1 basic frame, twice
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, P);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, P);

    // Even parity good, then flipped parity bit
    send_frame(8'h37, 1'b1, PARITY_EVEN, 1'b0, 1'b1, P);
    send_frame(8'h37, 1'b1, PARITY_EVEN, 1'b1, 1'b1, P);
    check("par_err_hold", 32'(p_data), 32'h37);

    // Stop error followed by a break
    mark = pulse_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    rx = 1'b0;
    repeat (30 * P) @(posedge clk);
    #1;
    check("break_pulses", pulse_cnt - mark, 1);
    check("break_p_data", 32'(p_data), 32'h37);
    idle_cycles(2 * P);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, P);

    // Two-cycle glitch is rejected at the start vote
    rx  = 1'b0;
    t_g = cyc;
    repeat (2) @(posedge clk);
    #1;
    rx = 1'b1;
    @(negedge clk);
    while (cyc < t_g + P / 2 + 3) @(negedge clk);
    check("glitch_in_start", 32'(dut.state_q), 32'(ST_START));
    @(negedge clk);
    check("glitch_idle", 32'(dut.state_q), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    idle_cycles(2 * P);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, P);

    // Back-to-back frames, then reset in the middle of a third
    mark = dv_cnt;
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    rx = 1'b0;
    repeat (P) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (3 * P) @(posedge clk);
    #1;
    rst = 1'b1;
    model_pdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("b2b_dv_count", dv_cnt - mark, 2);
    check("rst_p_data", 32'(p_data), 32'h0);
    check("rst_pulses", 32'({dv, perr, serr}), 32'h0);
    check("rst_pending", exp_q.size(), 0);
    rst = 1'b0;
    idle_cycles(2 * P);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, P);

    // Random frames: data, parity mode, errors and inter-frame gaps
    for (int k = 0; k < 40; k++) begin
      rd     = 8'($urandom);
      r_pen  = 1'($urandom);
      r_flip = r_pen && ($urandom_range(0, 5) == 0);
      r_stop = ($urandom_range(0, 7) != 0);
      r_gap  = $urandom_range(0, 2 * P);
      if (!r_stop && r_gap < 2) r_gap = 2;
      send_frame(rd, r_pen, 1'($urandom), r_flip, r_stop, r_gap);
    end

    idle_cycles(4 * P);
    check("final_pending", exp_q.size(), 0);
    check("final_p_data", 32'(p_data), 32'(model_pdata));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Receive-side counterpart of the UART transmitter; consumes the serial line that the transmitter drives.
- Oversamples the line at PRESCALE clocks per bit and detects the start bit.
- Majority-votes each bit at mid-bit, checks optional parity and the stop bit, and presents the deserialized word with a one-cycle valid pulse.
- Frame format matches the transmitter: start(0), DATA_WIDTH bits LSB first, optional parity, stop(1).

Parameters:
- DATA_WIDTH, 8: payload bits per frame.
- PRESCALE, 8: CLK cycles per bit. Must be even and ≥4; checked by elaboration-time assertion.

Ports:
- CLK  input  1  oversampling clock, PRESCALE × baud.
- RST  input  1  asynchronous, active-high reset.
- RX_IN  input  1  serial line; idles high; asynchronous to CLK.
- Parity_Enable  input  1  1 = frame carries a parity bit.
- Parity_Type  input  1  0 = even, 1 = odd.
- P_DATA  output  DATA_WIDTH  last correctly received word.
- Data_Valid  output  1  one-cycle pulse; P_DATA is new.
- Parity_Error  output  1  one-cycle pulse; parity mismatch.
- Stop_Error  output  1  one-cycle pulse; stop bit sampled 0.

Behaviour:
- Reset: all state registers go to IDLE. P_DATA=0, Data_Valid=0, Parity_Error=0, Stop_Error=0. Both synchronizer flops reset to 1, so no false start is seen on release.
- Input path: 2-flop synchronizer followed by 1 history flop. Start is detected only on a synchronized 1→0 transition while in IDLE. T0 is the first cycle the synchronized line is 0.
- Edge counter:
  - Counts 0..PRESCALE-1 per bit, with 0 at T0.
  - Samples are taken at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
  - The bit value is the 2-of-3 majority, formed in the cycle edge_cnt = PRESCALE/2+1.
- Bit counter tracks data index 0..DATA_WIDTH-1.
- Parity_Enable and Parity_Type are latched at T0 and held for the whole frame; changes mid-frame have no effect.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START on detected falling edge.
  - START: if the start vote is 1 (glitch), return to IDLE with no outputs. Otherwise go to DATA at edge_cnt wrap.
  - DATA: shift the voted bit into the shift register at position bit_cnt (LSB first). After DATA_WIDTH bits, go to PARITY if latched enable is set, else STOP.
  - PARITY: store the voted parity bit, go to STOP at wrap.
  - STOP: decide at the stop vote (mid-stop bit), register the outputs next cycle, and return to IDLE in that same next cycle. The remaining half stop bit is spent in IDLE, which permits back-to-back frames.
- Stop decision:
  - Expected parity = XOR(data) XOR Parity_Type.
  - Parity_Error = parity enabled AND stored parity ≠ expected.
  - Stop_Error = stop vote is 0.
  - Both error pulses may assert in the same cycle.
  - Data_Valid=1 and P_DATA updated only if neither error is set. On any error P_DATA holds its previous value.
- Latency:
  - N = 1 + DATA_WIDTH + Parity_Enable + 1 bits per frame.
  - The output pulse cycle is T0 + (N-1)·PRESCALE + PRESCALE/2 + 2.
  - For 8N1 at PRESCALE=8 this is T0+78; with parity it is T0+86.
  - T0 is 2 cycles after RX_IN falls (synchronizer).
- Break / line held low after Stop_Error: no new frame is started until the line returns high and falls again, because detection is edge-based.
- Reset mid-frame: immediate return to IDLE and the partial word is discarded.

Decomposition:
- Package uart_pkg holds:
  - FSM state enumeration (3-bit encoding).
  - Parity type constants PARITY_EVEN=0, PARITY_ODD=1.
  - Frame-length helper function for the bench.
- One sub-module, uart_rx_bit_sampler: contains the synchronizer, edge counter, 3-sample majority vote, and a sample_valid strobe. It is shared with the FSM in uart_rx_core.

Test Plan:
- Reset release with RX_IN held high for 500 cycles → Data_Valid, Parity_Error and Stop_Error never assert; P_DATA=0.
- 8N1, PRESCALE=8, send 0xA5 → single Data_Valid at T0+78, P_DATA=0xA5, no errors. Repeat via loopback from the transmitter and require the same value.
- Even parity, send 0x37 with parity bit 1 → Data_Valid at T0+86, P_DATA=0x37. Resend with the parity bit flipped → Parity_Error pulse, no Data_Valid, P_DATA stays 0x37.
- Send 0x55 with stop bit 0, then hold the line low for 30 bit-times → one Stop_Error pulse and no further activity. Raise the line, then send 0x0F → Data_Valid with P_DATA=0x0F.
- RX_IN low for 2 cycles then high → no frame outputs; FSM back in IDLE one cycle after the start vote; a following 0xC3 is received correctly.
- Back-to-back frames 0x00, 0xFF with no idle gap; assert RST mid third frame → exactly two Data_Valid pulses with the correct words. Reset clears all outputs, and a post-reset frame 0x3C is received correctly.
